// File: rtl/unsigned_div_pkg.sv
// Shared definitions for the sequential unsigned 16/8 divider.
// Contents: FSM state encoding, operand widths and the quotient value
// reported for a zero divisor.
package unsigned_div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;

    // All-ones quotient flags division by zero in-band as well as via div_by_zero.
    localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/unsigned_div_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   i_prem      8   partial remainder entering the step (always < divisor)
//   i_bit       1   next dividend bit, MSB first
//   i_divisor   8   divisor (non-zero while iterating)
//   o_prem      8   partial remainder leaving the step
//   o_qbit      1   quotient bit produced by this step
module unsigned_div_step
    import unsigned_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] i_prem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W-1:0] o_prem,
    output logic                 o_qbit
);

    logic [DIVISOR_W:0]   w_shifted;
    logic [DIVISOR_W+1:0] w_trial;

    // The shifted remainder needs 9 bits; one more bit carries the borrow so
    // the sign of the trial subtraction is never lost.
    assign w_shifted = {i_prem, i_bit};
    assign w_trial   = {1'b0, w_shifted} - {2'b00, i_divisor};
    assign o_qbit    = ~w_trial[DIVISOR_W+1];

    // Either result is below the divisor, so the low 8 bits are exact.
    assign o_prem = o_qbit ? w_trial[DIVISOR_W-1:0] : w_shifted[DIVISOR_W-1:0];

endmodule

// File: rtl/unsigned_16by8_div_seq.sv
// Iterative unsigned divider, 16-bit dividend by 8-bit divisor, one quotient
// bit per cycle (restoring). TRUNC (0..8) skips the low quotient bits, which
// are returned as 0, and shortens the run to 16-TRUNC iterations.
//
// state | meaning
// IDLE  | ready for a new operation
// BUSY  | iterating, one quotient bit per cycle
// DONE  | result presented, waiting for out_ready
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     operands present        in_ready     operation can be accepted
//   dividend 16  numerator               divisor 8    denominator
//   out_valid    result available        out_ready    consumer takes the result
//   quotient 16  result quotient         remainder 8  remainder (0 when TRUNC>0)
//   div_by_zero  divisor was 0 for this result
module unsigned_16by8_div_seq
    import unsigned_div_pkg::*;
#(
    parameter int TRUNC = 0
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int         ITER      = DIVIDEND_W - TRUNC;
    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    div_state_t r_state;
    div_state_t w_next_state;

    logic [DIVIDEND_W-1:0] r_work;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVISOR_W-1:0]  r_prem;
    logic [DIVIDEND_W-1:0] r_qbits;
    logic [4:0]            r_count;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_by_zero;

    logic [DIVISOR_W-1:0]  w_step_prem;
    logic                  w_step_qbit;
    logic [DIVIDEND_W-1:0] w_qbits_next;
    logic                  w_last_iter;
    logic                  w_div0;

    unsigned_div_step u_step (
        .i_prem    (r_prem),
        .i_bit     (r_work[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_prem    (w_step_prem),
        .o_qbit    (w_step_qbit)
    );

    assign w_qbits_next = {r_qbits[DIVIDEND_W-2:0], w_step_qbit};
    assign w_last_iter  = (r_count == LAST_ITER);
    assign w_div0       = (divisor == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next_state = w_div0 ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_last_iter) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_work        <= '0;
            r_divisor     <= '0;
            r_prem        <= '0;
            r_qbits       <= '0;
            r_count       <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work    <= dividend;
                        r_divisor <= divisor;
                        r_prem    <= '0;
                        r_qbits   <= '0;
                        r_count   <= '0;
                        if (w_div0) begin
                            r_quotient    <= DIV0_QUOTIENT;
                            r_remainder   <= '0;
                            r_div_by_zero <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    r_work  <= {r_work[DIVIDEND_W-2:0], 1'b0};
                    r_prem  <= w_step_prem;
                    r_qbits <= w_qbits_next;
                    r_count <= r_count + 5'd1;
                    if (w_last_iter) begin
                        // Computed bits are the top ITER quotient bits; realign them.
                        r_quotient    <= w_qbits_next << TRUNC;
                        r_remainder   <= (TRUNC == 0) ? w_step_prem : '0;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
